// File: rtl/mrna_iso_pkg.sv
// Shared definitions for the mRNA isolation sequencer: step codes, valve bit
// positions, per-step valve masks and peristaltic pump phase patterns.
package mrna_iso_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_CELLS   = 4'd1,
    S_LYSE    = 4'd2,
    S_BEADS   = 4'd3,
    S_MIX     = 4'd4,
    S_SEP     = 4'd5,
    S_COLLECT = 4'd6,
    S_FLUSH   = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  localparam int unsigned VALVE_W       = 11;
  localparam int unsigned V_CELLS_IN    = 0;
  localparam int unsigned V_CELLS_OUT   = 1;
  localparam int unsigned V_COLLECT     = 2;
  localparam int unsigned V_LYSIS_IN    = 3;
  localparam int unsigned V_LYSIS_WASTE = 4;
  localparam int unsigned V_BEADS_IN    = 5;
  localparam int unsigned V_BEAD_WASTE  = 6;
  localparam int unsigned V_PUSH        = 7;
  localparam int unsigned V_SEP         = 8;
  localparam int unsigned V_SIEVE       = 9;
  localparam int unsigned V_WASTE       = 10;

  localparam logic [VALVE_W-1:0] V_BIT = 11'b1;

  // A set bit keeps the valve pressurised (closed); masks clear the open ones.
  localparam logic [VALVE_W-1:0] MASK_ALL_CLOSED = '1;
  localparam logic [VALVE_W-1:0] MASK_CELLS =
    ~((V_BIT << V_CELLS_IN) | (V_BIT << V_CELLS_OUT));
  localparam logic [VALVE_W-1:0] MASK_LYSE =
    ~((V_BIT << V_LYSIS_IN) | (V_BIT << V_LYSIS_WASTE) | (V_BIT << V_PUSH));
  localparam logic [VALVE_W-1:0] MASK_BEADS =
    ~((V_BIT << V_BEADS_IN) | (V_BIT << V_BEAD_WASTE) | (V_BIT << V_PUSH));
  localparam logic [VALVE_W-1:0] MASK_SEP =
    ~((V_BIT << V_SEP) | (V_BIT << V_SIEVE) | (V_BIT << V_WASTE));
  localparam logic [VALVE_W-1:0] MASK_COLLECT =
    ~((V_BIT << V_SEP) | (V_BIT << V_COLLECT));
  localparam logic [VALVE_W-1:0] MASK_FLUSH =
    ~((V_BIT << V_WASTE) | (V_BIT << V_LYSIS_WASTE) |
      (V_BIT << V_BEAD_WASTE) | (V_BIT << V_CELLS_OUT));

  localparam logic [2:0] PUMP_OFF = 3'b111;
  localparam logic [2:0] PUMP_PH0 = 3'b011;
  localparam logic [2:0] PUMP_PH1 = 3'b101;
  localparam logic [2:0] PUMP_PH2 = 3'b110;

  function automatic logic [VALVE_W-1:0] valve_mask(input state_t s);
    case (s)
      S_CELLS:   return MASK_CELLS;
      S_LYSE:    return MASK_LYSE;
      S_BEADS:   return MASK_BEADS;
      S_SEP:     return MASK_SEP;
      S_COLLECT: return MASK_COLLECT;
      S_FLUSH:   return MASK_FLUSH;
      default:   return MASK_ALL_CLOSED;
    endcase
  endfunction

  function automatic logic [2:0] pump_pattern(input logic [1:0] phase);
    case (phase)
      2'd0:    return PUMP_PH0;
      2'd1:    return PUMP_PH1;
      default: return PUMP_PH2;
    endcase
  endfunction

endpackage

// File: rtl/peristaltic_phase_gen.sv
// Three-phase peristaltic pump driver: a phase divider feeding a rotator that
// counts full rotations and flags the last cycle of the final one.
module peristaltic_phase_gen
  import mrna_iso_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] pump_div,
  input  logic [7:0]       rotations,
  output logic [2:0]       pump,
  output logic             finished
);

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       phase;
  logic [7:0]       rot_cnt;
  logic [7:0]       rot_last;
  logic             active;
  logic             phase_end;

  assign rot_last  = (rotations == 8'd0) ? 8'd0 : rotations - 8'd1;
  assign phase_end = (div_cnt == pump_div);
  assign finished  = active && phase_end && (phase == 2'd2) && (rot_cnt == rot_last);

  // en reflects the sequencer's next state, so pump moves on the same edge
  // as the step change and the first phase is loaded on entry.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      active  <= 1'b0;
      div_cnt <= '0;
      phase   <= 2'd0;
      rot_cnt <= '0;
      pump    <= PUMP_OFF;
    end else if (!active) begin
      active  <= 1'b1;
      div_cnt <= '0;
      phase   <= 2'd0;
      rot_cnt <= '0;
      pump    <= PUMP_PH0;
    end else if (phase_end) begin
      div_cnt <= '0;
      if (phase == 2'd2) begin
        phase   <= 2'd0;
        rot_cnt <= rot_cnt + 8'd1;
        pump    <= PUMP_PH0;
      end else begin
        phase <= phase + 2'd1;
        pump  <= pump_pattern(phase + 2'd1);
      end
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mrna_iso_sequencer.sv
// Microfluidic mRNA isolation step sequencer: walks the fixed protocol,
// times each step and drives registered valve and pump control lines.
module mrna_iso_sequencer
  import mrna_iso_pkg::*;
#(
  parameter int DUR_W = 16,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [DUR_W-1:0] dur_cells,
  input  logic [DUR_W-1:0] dur_lyse,
  input  logic [DUR_W-1:0] dur_beads,
  input  logic [DUR_W-1:0] dur_sep,
  input  logic [DUR_W-1:0] dur_collect,
  input  logic [DUR_W-1:0] dur_flush,
  input  logic [7:0]       mix_cycles,
  input  logic [DIV_W-1:0] pump_div,
  output logic [10:0]      valve_ctl,
  output logic [2:0]       pump_ctl,
  output logic [3:0]       step,
  output logic             busy,
  output logic             done
);

  state_t           state, state_next;
  logic [DUR_W-1:0] timer, timer_next;
  logic [DUR_W-1:0] c_lyse, c_beads, c_sep, c_collect, c_flush;
  logic [7:0]       c_mix;
  logic [DIV_W-1:0] c_div;
  logic             accept;
  logic             expired;
  logic             abortable;
  logic             mix_finished;

  // Timer holds remaining cycles minus one, so a zero duration still lasts one.
  function automatic logic [DUR_W-1:0] last_tick(input logic [DUR_W-1:0] d);
    return (d == '0) ? '0 : d - DUR_W'(1);
  endfunction

  assign accept    = (state == S_IDLE) && start;
  assign expired   = (timer == '0);
  assign abortable = (state inside {S_CELLS, S_LYSE, S_BEADS, S_MIX, S_SEP, S_COLLECT});
  assign step      = state;

  always_comb begin
    state_next = state;
    timer_next = expired ? '0 : timer - DUR_W'(1);
    case (state)
      S_IDLE: if (start) begin
        state_next = S_CELLS;
        timer_next = last_tick(dur_cells);
      end
      S_CELLS: if (expired) begin
        state_next = S_LYSE;
        timer_next = last_tick(c_lyse);
      end
      S_LYSE: if (expired) begin
        state_next = S_BEADS;
        timer_next = last_tick(c_beads);
      end
      S_BEADS: if (expired) begin
        state_next = S_MIX;
        timer_next = '0;
      end
      S_MIX: if (mix_finished) begin
        state_next = S_SEP;
        timer_next = last_tick(c_sep);
      end
      S_SEP: if (expired) begin
        state_next = S_COLLECT;
        timer_next = last_tick(c_collect);
      end
      S_COLLECT: if (expired) begin
        state_next = S_FLUSH;
        timer_next = last_tick(c_flush);
      end
      S_FLUSH: if (expired) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    // Abort overrides any timer-driven transition taken above.
    if (abortable && abort) begin
      state_next = S_FLUSH;
      timer_next = last_tick(c_flush);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      timer     <= '0;
      c_lyse    <= '0;
      c_beads   <= '0;
      c_sep     <= '0;
      c_collect <= '0;
      c_flush   <= '0;
      c_mix     <= '0;
      c_div     <= '0;
      valve_ctl <= '1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      timer     <= timer_next;
      valve_ctl <= valve_mask(state_next);
      busy      <= (state_next inside {S_CELLS, S_LYSE, S_BEADS, S_MIX,
                                       S_SEP, S_COLLECT, S_FLUSH});
      done      <= (state_next == S_DONE);
      if (accept) begin
        c_lyse    <= dur_lyse;
        c_beads   <= dur_beads;
        c_sep     <= dur_sep;
        c_collect <= dur_collect;
        c_flush   <= dur_flush;
        c_mix     <= mix_cycles;
        c_div     <= pump_div;
      end
    end
  end

  peristaltic_phase_gen #(
    .DIV_W(DIV_W)
  ) u_phase_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (state_next == S_MIX),
    .pump_div (c_div),
    .rotations(c_mix),
    .pump     (pump_ctl),
    .finished (mix_finished)
  );

endmodule
